arp_bind_table: RTL and testbench
=================================

Name: arp_bind_table

Overview:
- Parametrised IP-to-MAC binding table for the ARP-defence output-port-lookup path; successor to the single-key learning CAM LUT.
- Learns IP/MAC bindings from ARP traffic and flags any packet that claims a bound IP with a different MAC as spoofing.
- Adds per-entry aging, saturating conflict counters, a sticky alarm and a software clear.
- Matching uses an internal register-array CAM (no black-box core); it sits beside the header parser and feeds the drop/forward decision.

Parameters:
- IP_WIDTH, 32, width of IP key
- MAC_WIDTH, 48, width of bound MAC
- DEPTH_BITS, 4, log2 of entry count
- DEPTH, 2**DEPTH_BITS, number of entries
- AGE_BITS, 8, per-entry age counter width; reload value is all-ones
- CNT_BITS, 4, per-entry conflict counter width
- ALARM_THRESH, 4, conflict count at which alarm asserts (1..2**CNT_BITS-1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- lookup_req  in  1  request; sampled only when ready=1
- ip_in  in  IP_WIDTH  sender IP of the ARP packet
- mac_in  in  MAC_WIDTH  sender MAC of the ARP packet
- opcode  in  16  ARP opcode (1 = request, 2 = reply)
- age_tick  in  1  one-cycle aging strobe
- clear_req  in  1  flush table and clear alarm
- ready  out  1  high in IDLE only
- lookup_done  out  1  one-cycle pulse; result outputs are valid on this cycle
- bind_hit  out  1  IP bound to the same MAC
- bind_miss  out  1  IP not present
- spoof_detected  out  1  IP bound to a different MAC
- learned  out  1  new binding written
- alarm  out  1  sticky; some entry's conflict count reached ALARM_THRESH
- entry_count  out  DEPTH_BITS+1  number of valid entries

Behaviour:
- Reset, asynchronous: state=FLUSH, all outputs 0, sweep index 0, replacement pointer 0.
- FLUSH
  - Clears one entry per cycle: valid, age and conflict count to 0.
  - Takes DEPTH cycles, then moves to IDLE.
  - ready first rises the cycle after the final entry is cleared.
  - age_tick, lookup_req and clear_req are ignored during FLUSH.
- IDLE
  - ready=1.
  - clear_req takes priority over lookup_req: clears alarm, enters FLUSH.
  - On lookup_req, latches ip_in, mac_in and opcode, then moves to SEARCH.
- SEARCH
  - Compares the latched IP against all valid entries in one cycle.
  - If several entries match, the lowest index wins.
  - Also computes the lowest-index free entry.
  - Moves to UPDATE.
- UPDATE: applies exactly one outcome, pulses lookup_done with exactly one of bind_hit/bind_miss/spoof_detected, then returns to IDLE. Accept-to-done latency is 2 cycles; back-to-back lookups complete every 3 cycles.
- Outcome: match with equal MAC
  - bind_hit=1.
  - Age reloads to all-ones.
  - Conflict count is unchanged.
- Outcome: match with different MAC
  - spoof_detected=1.
  - Binding and age are unchanged.
  - Conflict count increments, saturating at 2**CNT_BITS-1.
  - alarm sets once the count reaches or exceeds ALARM_THRESH.
- Outcome: miss with opcode 1 or 2
  - bind_miss=1, learned=1.
  - Writes {IP, MAC} with valid=1, age all-ones, count 0.
  - Target is the lowest free index. If the table is full, the target is the replacement pointer, which then advances and wraps from DEPTH-1 to 0.
- Outcome: miss with any other opcode: bind_miss=1 only, nothing is written.
- Aging
  - On age_tick in IDLE, SEARCH or UPDATE, every valid entry's age decrements by 1.
  - An entry whose age is 1 becomes invalid (valid=0, count=0).
  - If age_tick coincides with an UPDATE write or refresh to an entry, the update wins for that entry and the others still decrement.
  - An entry that ages out during SEARCH still completes the lookup using the SEARCH-cycle snapshot.
- entry_count is registered and updates the cycle after any valid-bit change.
- alarm clears only via reset or clear_req; clear_req outside IDLE is dropped.
- Reset mid-lookup aborts the lookup: no lookup_done pulse, and FLUSH restarts.

Decomposition:
- Package arp_bind_pkg:
  - state encodings FLUSH, IDLE, SEARCH, UPDATE
  - ARP_OP_REQUEST=16'h0001, ARP_OP_REPLY=16'h0002
  - outcome enum HIT, MISS, SPOOF
- Sub-module arp_bind_match, combinational:
  - inputs: key, valid vector, key array
  - outputs: match, match_idx (priority encoder), free_found, free_idx

Test Plan:
- Reset, then wait: ready rises exactly 16 cycles after reset deasserts; entry_count=0, alarm=0.
- Lookup IP 10.0.0.1, MAC 00:11:22:33:44:55, opcode 2 -> done 2 cycles later with bind_miss=1, learned=1; entry_count=1. Repeating it gives bind_hit=1, learned=0.
- Same IP with MAC 66:77:88:99:AA:BB sent 4 times -> spoof_detected=1 each time, binding unchanged, alarm rises on the 4th done; clear_req then drops alarm and entry_count to 0 after the flush.
- Learn 16 distinct IPs, then a 17th -> entry 0 is overwritten (pointer 0 to 1); a lookup of the first IP gives bind_miss; entry_count stays 16.
- Learn one IP, then 255 age_ticks -> entry invalid, entry_count=0. Refresh on tick 254 coincident with an age_tick -> the entry survives with age 255.
- Miss with opcode 3 -> bind_miss=1, learned=0, entry_count unchanged. Assert reset during SEARCH -> no lookup_done pulse, FLUSH restarts.

Source files
------------

// File: rtl/arp_bind_pkg.sv
// Shared definitions for the ARP IP-to-MAC binding table:
// FSM state codes, ARP opcodes and the lookup outcome type.
package arp_bind_pkg;

    localparam logic [1:0] ST_FLUSH  = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_SEARCH = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

    typedef enum logic [1:0] {
        HIT   = 2'd0,
        MISS  = 2'd1,
        SPOOF = 2'd2
    } outcome_e;

    // Only genuine ARP request/reply traffic is allowed to create bindings.
    function automatic logic is_arp_op(input logic [15:0] op);
        return (op == ARP_OP_REQUEST) || (op == ARP_OP_REPLY);
    endfunction

endpackage

// File: rtl/arp_bind_match.sv
// Register-array CAM match logic (combinational).
// Ports: key, valid vector, key array in; match/match_idx
// (lowest matching index) and free_found/free_idx (lowest free index) out.
module arp_bind_match
    import arp_bind_pkg::*;
#(
    parameter int IP_WIDTH   = 32,
    parameter int DEPTH_BITS = 4,
    parameter int DEPTH      = 2**DEPTH_BITS
) (
    input  logic [IP_WIDTH-1:0]            key,
    input  logic [DEPTH-1:0]               valid,
    input  logic [DEPTH-1:0][IP_WIDTH-1:0] keys,
    output logic                           match,
    output logic [DEPTH_BITS-1:0]          match_idx,
    output logic                           free_found,
    output logic [DEPTH_BITS-1:0]          free_idx
);

    // Scan from the top down so the lowest index is the last to assign.
    always_comb begin
        match      = 1'b0;
        match_idx  = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid[i] && (keys[i] == key)) begin
                match     = 1'b1;
                match_idx = i[DEPTH_BITS-1:0];
            end
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = i[DEPTH_BITS-1:0];
            end
        end
    end

endmodule

// File: rtl/arp_bind_table.sv
// IP-to-MAC binding table with learning, aging, conflict counters and alarm.
// Ports: clk/reset; lookup_req, ip_in, mac_in, opcode, age_tick, clear_req in;
// ready, lookup_done, bind_hit/miss, spoof_detected, learned, alarm,
// entry_count out.
module arp_bind_table
    import arp_bind_pkg::*;
#(
    parameter int IP_WIDTH     = 32,
    parameter int MAC_WIDTH    = 48,
    parameter int DEPTH_BITS   = 4,
    parameter int DEPTH        = 2**DEPTH_BITS,
    parameter int AGE_BITS     = 8,
    parameter int CNT_BITS     = 4,
    parameter int ALARM_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_req,
    input  logic [IP_WIDTH-1:0]   ip_in,
    input  logic [MAC_WIDTH-1:0]  mac_in,
    input  logic [15:0]           opcode,
    input  logic                  age_tick,
    input  logic                  clear_req,
    output logic                  ready,
    output logic                  lookup_done,
    output logic                  bind_hit,
    output logic                  bind_miss,
    output logic                  spoof_detected,
    output logic                  learned,
    output logic                  alarm,
    output logic [DEPTH_BITS:0]   entry_count
);

    logic [1:0]                     state_q, state_d;
    logic [DEPTH_BITS-1:0]          flush_idx_q, flush_idx_d;
    logic [DEPTH_BITS-1:0]          rep_ptr_q, rep_ptr_d;
    logic [IP_WIDTH-1:0]            req_ip_q, req_ip_d;
    logic [MAC_WIDTH-1:0]           req_mac_q, req_mac_d;
    logic [15:0]                    req_op_q, req_op_d;
    outcome_e                       outcome_q, outcome_d;
    logic [DEPTH_BITS-1:0]          tgt_idx_q, tgt_idx_d;
    logic                           learn_q, learn_d;
    logic                           adv_q, adv_d;
    logic                           alarm_q, alarm_d;
    logic [DEPTH_BITS:0]            count_q, count_d;

    logic [DEPTH-1:0]                valid_q, valid_d;
    logic [DEPTH-1:0][IP_WIDTH-1:0]  ip_q, ip_d;
    logic [DEPTH-1:0][MAC_WIDTH-1:0] mac_q, mac_d;
    logic [DEPTH-1:0][AGE_BITS-1:0]  age_q, age_d;
    logic [DEPTH-1:0][CNT_BITS-1:0]  cnt_q, cnt_d;

    logic                  m_hit;
    logic [DEPTH_BITS-1:0] m_idx;
    logic                  f_found;
    logic [DEPTH_BITS-1:0] f_idx;
    logic [CNT_BITS-1:0]   cnt_inc;

    arp_bind_match #(
        .IP_WIDTH   (IP_WIDTH),
        .DEPTH_BITS (DEPTH_BITS),
        .DEPTH      (DEPTH)
    ) u_match (
        .key        (req_ip_q),
        .valid      (valid_q),
        .keys       (ip_q),
        .match      (m_hit),
        .match_idx  (m_idx),
        .free_found (f_found),
        .free_idx   (f_idx)
    );

    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        rep_ptr_d   = rep_ptr_q;
        req_ip_d    = req_ip_q;
        req_mac_d   = req_mac_q;
        req_op_d    = req_op_q;
        outcome_d   = outcome_q;
        tgt_idx_d   = tgt_idx_q;
        learn_d     = learn_q;
        adv_d       = adv_q;
        alarm_d     = alarm_q;
        valid_d     = valid_q;
        ip_d        = ip_q;
        mac_d       = mac_q;
        age_d       = age_q;
        cnt_d       = cnt_q;
        cnt_inc     = '0;

        // Aging runs first; an UPDATE write below overrides its entry.
        if ((state_q != ST_FLUSH) && age_tick) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i]) begin
                    if (age_q[i] == AGE_BITS'(1)) begin
                        valid_d[i] = 1'b0;
                        age_d[i]   = '0;
                        cnt_d[i]   = '0;
                    end else begin
                        age_d[i] = age_q[i] - AGE_BITS'(1);
                    end
                end
            end
        end

        case (state_q)
            ST_FLUSH: begin
                valid_d[flush_idx_q] = 1'b0;
                age_d[flush_idx_q]   = '0;
                cnt_d[flush_idx_q]   = '0;
                flush_idx_d          = flush_idx_q + 1'b1;
                if (flush_idx_q == DEPTH_BITS'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    alarm_d     = 1'b0;
                    flush_idx_d = '0;
                    state_d     = ST_FLUSH;
                end else if (lookup_req) begin
                    req_ip_d  = ip_in;
                    req_mac_d = mac_in;
                    req_op_d  = opcode;
                    state_d   = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                // Decision is frozen here so same-cycle aging cannot alter it.
                adv_d   = 1'b0;
                learn_d = 1'b0;
                if (m_hit) begin
                    tgt_idx_d = m_idx;
                    outcome_d = (mac_q[m_idx] == req_mac_q) ? HIT : SPOOF;
                end else begin
                    outcome_d = MISS;
                    learn_d   = is_arp_op(req_op_q);
                    tgt_idx_d = f_found ? f_idx : rep_ptr_q;
                    adv_d     = !f_found;
                end
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
                case (outcome_q)
                    HIT: begin
                        valid_d[tgt_idx_q] = 1'b1;
                        age_d[tgt_idx_q]   = '1;
                        cnt_d[tgt_idx_q]   = cnt_q[tgt_idx_q];
                    end
                    SPOOF: begin
                        // An entry that just aged out has no count to bump.
                        if (valid_d[tgt_idx_q]) begin
                            cnt_inc = (cnt_q[tgt_idx_q] == '1) ?
                                      cnt_q[tgt_idx_q] :
                                      cnt_q[tgt_idx_q] + 1'b1;
                            cnt_d[tgt_idx_q] = cnt_inc;
                            if (cnt_inc >= CNT_BITS'(ALARM_THRESH)) begin
                                alarm_d = 1'b1;
                            end
                        end
                    end
                    MISS: begin
                        if (learn_q) begin
                            valid_d[tgt_idx_q] = 1'b1;
                            ip_d[tgt_idx_q]    = req_ip_q;
                            mac_d[tgt_idx_q]   = req_mac_q;
                            age_d[tgt_idx_q]   = '1;
                            cnt_d[tgt_idx_q]   = '0;
                            if (adv_q) begin
                                rep_ptr_d = rep_ptr_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    // Population count lags the valid bits by one cycle.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + {{DEPTH_BITS{1'b0}}, valid_q[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FLUSH;
            flush_idx_q <= '0;
            rep_ptr_q   <= '0;
            req_ip_q    <= '0;
            req_mac_q   <= '0;
            req_op_q    <= '0;
            outcome_q   <= HIT;
            tgt_idx_q   <= '0;
            learn_q     <= 1'b0;
            adv_q       <= 1'b0;
            alarm_q     <= 1'b0;
            count_q     <= '0;
            valid_q     <= '0;
            ip_q        <= '0;
            mac_q       <= '0;
            age_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
            rep_ptr_q   <= rep_ptr_d;
            req_ip_q    <= req_ip_d;
            req_mac_q   <= req_mac_d;
            req_op_q    <= req_op_d;
            outcome_q   <= outcome_d;
            tgt_idx_q   <= tgt_idx_d;
            learn_q     <= learn_d;
            adv_q       <= adv_d;
            alarm_q     <= alarm_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            ip_q        <= ip_d;
            mac_q       <= mac_d;
            age_q       <= age_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ready          = (state_q == ST_IDLE);
    assign lookup_done    = (state_q == ST_UPDATE);
    assign bind_hit       = lookup_done && (outcome_q == HIT);
    assign bind_miss      = lookup_done && (outcome_q == MISS);
    assign spoof_detected = lookup_done && (outcome_q == SPOOF);
    assign learned        = bind_miss && learn_q;
    assign alarm          = alarm_q;
    assign entry_count    = count_q;

endmodule

// File: tb/tb_arp_bind_table.sv
// Scoreboard bench for arp_bind_table: directed lookups push expected
// results; a negedge monitor pops and compares on every lookup_done.
module tb_arp_bind_table;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lookup_req = 1'b0;
    logic [31:0] ip_in = '0;
    logic [47:0] mac_in = '0;
    logic [15:0] opcode = '0;
    logic        age_tick = 1'b0;
    logic        clear_req = 1'b0;
    logic        ready, lookup_done, bind_hit, bind_miss;
    logic        spoof_detected, learned, alarm;
    logic [4:0]  entry_count;

    typedef struct packed {
        logic hit;
        logic miss;
        logic spoof;
        logic lrn;
    } exp_t;

    localparam exp_t E_HIT   = '{hit: 1'b1, miss: 1'b0, spoof: 1'b0, lrn: 1'b0};
    localparam exp_t E_LEARN = '{hit: 1'b0, miss: 1'b1, spoof: 1'b0, lrn: 1'b1};
    localparam exp_t E_MISS  = '{hit: 1'b0, miss: 1'b1, spoof: 1'b0, lrn: 1'b0};
    localparam exp_t E_SPOOF = '{hit: 1'b0, miss: 1'b0, spoof: 1'b1, lrn: 1'b0};

    localparam logic [31:0] IP_A  = 32'h0A00_0001;
    localparam logic [47:0] MAC_1 = 48'h0011_2233_4455;
    localparam logic [47:0] MAC_2 = 48'h6677_8899_AABB;

    exp_t exp_q[$];
    int   nchecks = 0;
    int   nerrors = 0;
    int   ndone = 0;

    arp_bind_table #(
        .IP_WIDTH     (32),
        .MAC_WIDTH    (48),
        .DEPTH_BITS   (4),
        .DEPTH        (16),
        .AGE_BITS     (8),
        .CNT_BITS     (4),
        .ALARM_THRESH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_req     (lookup_req),
        .ip_in          (ip_in),
        .mac_in         (mac_in),
        .opcode         (opcode),
        .age_tick       (age_tick),
        .clear_req      (clear_req),
        .ready          (ready),
        .lookup_done    (lookup_done),
        .bind_hit       (bind_hit),
        .bind_miss      (bind_miss),
        .spoof_detected (spoof_detected),
        .learned        (learned),
        .alarm          (alarm),
        .entry_count    (entry_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        nchecks++;
        if (act !== req) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (lookup_done === 1'b1) begin
            ndone++;
            if (exp_q.size() == 0) begin
                nchecks++;
                nerrors++;
                $display("FAIL unexpected_done: got hit=%b miss=%b spoof=%b",
                         bind_hit, bind_miss, spoof_detected);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result{hit,miss,spoof,learned}",
                    {bind_hit, bind_miss, spoof_detected, learned}, e);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", ready, 1);
    endtask

    // Issue one lookup; optionally strobe age_tick during the UPDATE cycle.
    task automatic lookup(input logic [31:0] ip, input logic [47:0] mac,
                          input logic [15:0] op, input exp_t e,
                          input bit tick_upd);
        wait_ready();
        exp_q.push_back(e);
        ip_in      = ip;
        mac_in     = mac;
        opcode     = op;
        lookup_req = 1'b1;
        @(negedge clk);
        lookup_req = 1'b0;
        chk("search_no_done", lookup_done, 0);
        @(negedge clk);
        chk("done_latency", lookup_done, 1);
        age_tick = tick_upd;
        @(negedge clk);
        age_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        age_tick = 1'b1;
        repeat (n) @(negedge clk);
        age_tick = 1'b0;
    endtask

    task automatic check_count(input string name, input int req);
        @(negedge clk);
        chk(name, entry_count, req);
    endtask

    task automatic do_clear();
        wait_ready();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        chk("clear_alarm", alarm, 0);
        chk("clear_not_ready", ready, 0);
        wait_ready();
        check_count("clear_count", 0);
    endtask

    // Release reset between edges and count edges until ready rises.
    task automatic release_reset();
        int c;
        c = 0;
        reset = 1'b0;
        while (!ready && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("ready_latency", c, 16);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_done", lookup_done, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_count", entry_count, 0);
        release_reset();
        chk("init_count", entry_count, 0);
        chk("init_alarm", alarm, 0);

        // Learn then hit.
        lookup(IP_A, MAC_1, 16'd2, E_LEARN, 1'b0);
        check_count("learn_count", 1);
        lookup(IP_A, MAC_1, 16'd2, E_HIT, 1'b0);

        // Four spoof attempts; alarm at the fourth.
        for (int i = 1; i <= 4; i++) begin
            lookup(IP_A, MAC_2, 16'd2, E_SPOOF, 1'b0);
            chk($sformatf("alarm_after_spoof%0d", i), alarm, (i >= 4));
        end
        lookup(IP_A, MAC_1, 16'd1, E_HIT, 1'b0);
        check_count("spoof_count", 1);
        do_clear();

        // Fill the table, then force a replacement.
        for (int i = 0; i < 16; i++) begin
            lookup(32'h0A00_0100 + i, 48'h02_0000_0000 + i, 16'd1,
                   E_LEARN, 1'b0);
        end
        check_count("full_count", 16);
        lookup(32'h0A00_0101, 48'h02_0000_0001, 16'd2, E_HIT, 1'b0);
        lookup(32'h0A00_01FF, 48'h02_0000_00FF, 16'd2, E_LEARN, 1'b0);
        check_count("replace_count", 16);
        lookup(32'h0A00_0100, 48'h02_0000_0000, 16'd3, E_MISS, 1'b0);
        lookup(32'h0A00_01FF, 48'h02_0000_00FF, 16'd2, E_HIT, 1'b0);
        lookup(32'h0A00_0101, 48'h02_0000_0001, 16'd2, E_HIT, 1'b0);
        // Pointer should now be 1: next replacement evicts entry 1.
        lookup(32'h0A00_02FE, 48'h02_0000_02FE, 16'd1, E_LEARN, 1'b0);
        lookup(32'h0A00_0101, 48'h02_0000_0001, 16'd3, E_MISS, 1'b0);
        lookup(32'h0A00_0102, 48'h02_0000_0002, 16'd3, E_HIT, 1'b0);
        do_clear();

        // Aging out after 255 ticks.
        lookup(IP_A, MAC_1, 16'd2, E_LEARN, 1'b0);
        ticks(254);
        check_count("age254_count", 1);
        ticks(1);
        check_count("age255_count", 0);
        lookup(IP_A, MAC_1, 16'd3, E_MISS, 1'b0);

        // Refresh coincident with tick 254 keeps the entry alive.
        lookup(IP_A, MAC_1, 16'd2, E_LEARN, 1'b0);
        ticks(253);
        lookup(IP_A, MAC_1, 16'd2, E_HIT, 1'b1);
        ticks(254);
        check_count("refresh_count", 1);
        lookup(IP_A, MAC_1, 16'd3, E_HIT, 1'b0);

        // Non-ARP opcode miss: no learning.
        lookup(32'hC0A8_0001, MAC_2, 16'd3, E_MISS, 1'b0);
        check_count("op3_count", 1);
        chk("op3_alarm", alarm, 0);

        // Reset during SEARCH aborts the lookup.
        wait_ready();
        ip_in      = 32'hC0A8_0002;
        mac_in     = MAC_2;
        opcode     = 16'd2;
        lookup_req = 1'b1;
        @(negedge clk);
        lookup_req = 1'b0;
        d0 = ndone;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", ndone - d0, 0);
        chk("abort_done_low", lookup_done, 0);
        chk("abort_count", entry_count, 0);
        release_reset();
        chk("abort_no_done_after", ndone - d0, 0);
        lookup(32'hC0A8_0002, MAC_2, 16'd2, E_LEARN, 1'b0);
        check_count("post_reset_count", 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

endmodule
